// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encodings, the eight-direction table
// and the move_sequencer state encoding.
package othello_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  // dr/dc are 2-bit two's complement deltas; step is the matching linear offset.
  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
    logic [4:0] step;
  } dir_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_ORIGIN,
    CHK_ORIGIN,
    DIR_SETUP,
    RD,
    CHK,
    LOAD,
    FLIP,
    NEXT_DIR,
    PLACE,
    DONE
  } state_t;

  // Fixed visiting order: E, W, S, N, SE, NW, SW, NE.
  function automatic dir_t dir_entry(input logic [2:0] d);
    dir_t e;
    e = '{dr: 2'b00, dc: 2'b01, step: 5'b00001};
    case (d)
      3'd0: e = '{dr: 2'b00, dc: 2'b01, step: 5'b00001};
      3'd1: e = '{dr: 2'b00, dc: 2'b11, step: 5'b11111};
      3'd2: e = '{dr: 2'b01, dc: 2'b00, step: 5'b01000};
      3'd3: e = '{dr: 2'b11, dc: 2'b00, step: 5'b11000};
      3'd4: e = '{dr: 2'b01, dc: 2'b01, step: 5'b01001};
      3'd5: e = '{dr: 2'b11, dc: 2'b11, step: 5'b10111};
      3'd6: e = '{dr: 2'b01, dc: 2'b11, step: 5'b00111};
      3'd7: e = '{dr: 2'b11, dc: 2'b01, step: 5'b11001};
      default: e = '{dr: 2'b00, dc: 2'b01, step: 5'b00001};
    endcase
    return e;
  endfunction

  function automatic logic [1:0] colour_of(input logic player);
    return player ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/dir_walker.sv
// One step from (r, c) in direction d, with an off-board flag so a run
// never wraps from one row into the next.
module dir_walker
  import othello_pkg::*;
(
  input  logic [2:0] r,
  input  logic [2:0] c,
  input  logic [2:0] d,
  output logic [2:0] next_r,
  output logic [2:0] next_c,
  output logic [6:0] addr,
  output logic       off_board
);

  dir_t       dir;
  logic [3:0] r_sum;
  logic [3:0] c_sum;

  assign dir   = dir_entry(d);
  assign r_sum = {1'b0, r} + {{2{dir.dr[1]}}, dir.dr};
  assign c_sum = {1'b0, c} + {{2{dir.dc[1]}}, dir.dc};

  // Leaving 0..7 yields either -1 (1111) or 8 (1000); both set bit 3.
  assign off_board = r_sum[3] | c_sum[3];
  assign next_r    = r_sum[2:0];
  assign next_c    = c_sum[2:0];
  assign addr      = {1'b0, r_sum[2:0], c_sum[2:0]};

endmodule

// File: rtl/move_sequencer.sv
// Executes one Othello move: origin check, eight-direction scan, flipper
// hand-off per enclosing direction, disc placement and result report.
module move_sequencer
  import othello_pkg::*;
#(
  parameter int FLIP_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       player,
  input  logic [6:0] s_addr,
  input  logic [1:0] mem_q,
  output logic [6:0] mem_addr,
  output logic       mem_wren,
  output logic [1:0] mem_data,
  output logic       mem_sel,
  output logic [6:0] s_addr_out,
  output logic [4:0] step_o,
  output logic       ld_o,
  output logic       start_flip,
  input  logic       s_done,
  output logic       done_o,
  output logic       move_valid,
  output logic [4:0] flips_total,
  output logic       err
);

  localparam int TW = $clog2(FLIP_TIMEOUT + 1);

  state_t        state, state_nx;
  logic          player_q, player_nx;
  logic [6:0]    s_addr_q, s_addr_nx;
  logic [2:0]    d_q, d_nx;
  logic [2:0]    n_q, n_nx;
  logic [2:0]    cur_r, cur_r_nx;
  logic [2:0]    cur_c, cur_c_nx;
  logic [6:0]    cur_addr, cur_addr_nx;
  logic [TW-1:0] tmo_q, tmo_nx;
  logic [4:0]    flips_nx;
  logic          valid_nx;
  logic          err_nx;

  dir_t       cur_dir;
  logic [1:0] own, opp;
  logic [2:0] walk_r, walk_c, next_r, next_c;
  logic [6:0] next_addr;
  logic       off_board;

  assign cur_dir = dir_entry(d_q);
  assign own     = colour_of(player_q);
  assign opp     = colour_of(~player_q);

  // The first neighbour is taken from the origin, later steps from cur.
  assign walk_r = (state == DIR_SETUP) ? s_addr_q[5:3] : cur_r;
  assign walk_c = (state == DIR_SETUP) ? s_addr_q[2:0] : cur_c;

  dir_walker u_walker (
    .r         (walk_r),
    .c         (walk_c),
    .d         (d_q),
    .next_r    (next_r),
    .next_c    (next_c),
    .addr      (next_addr),
    .off_board (off_board)
  );

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: no memories in this block, so every register takes an async reset value.
    if (!reset) begin
      state       <= IDLE;
      player_q    <= 1'b0;
      s_addr_q    <= '0;
      d_q         <= '0;
      n_q         <= '0;
      cur_r       <= '0;
      cur_c       <= '0;
      cur_addr    <= '0;
      tmo_q       <= '0;
      flips_total <= '0;
      move_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state       <= state_nx;
      player_q    <= player_nx;
      s_addr_q    <= s_addr_nx;
      d_q         <= d_nx;
      n_q         <= n_nx;
      cur_r       <= cur_r_nx;
      cur_c       <= cur_c_nx;
      cur_addr    <= cur_addr_nx;
      tmo_q       <= tmo_nx;
      flips_total <= flips_nx;
      move_valid  <= valid_nx;
      err         <= err_nx;
    end
  end

  always_comb begin
    // NOTE: every next-state value and output gets a default first, so no latches.
    state_nx    = state;
    player_nx   = player_q;
    s_addr_nx   = s_addr_q;
    d_nx        = d_q;
    n_nx        = n_q;
    cur_r_nx    = cur_r;
    cur_c_nx    = cur_c;
    cur_addr_nx = cur_addr;
    tmo_nx      = tmo_q;
    flips_nx    = flips_total;
    valid_nx    = move_valid;
    err_nx      = err;
    mem_addr    = '0;
    mem_wren    = 1'b0;
    mem_data    = EMPTY;
    mem_sel     = 1'b0;
    s_addr_out  = '0;
    step_o      = '0;
    ld_o        = 1'b0;
    start_flip  = 1'b0;
    done_o      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          player_nx = player;
          s_addr_nx = s_addr;
          flips_nx  = '0;
          valid_nx  = 1'b0;
          state_nx  = RD_ORIGIN;
        end
      end
      RD_ORIGIN: begin
        mem_addr = s_addr_q;
        state_nx = CHK_ORIGIN;
      end
      CHK_ORIGIN: begin
        if (mem_q != EMPTY) begin
          valid_nx = 1'b0;
          state_nx = DONE;
        end else begin
          d_nx     = '0;
          state_nx = DIR_SETUP;
        end
      end
      DIR_SETUP: begin
        n_nx = '0;
        if (off_board) begin
          state_nx = NEXT_DIR;
        end else begin
          cur_r_nx    = next_r;
          cur_c_nx    = next_c;
          cur_addr_nx = next_addr;
          state_nx    = RD;
        end
      end
      RD: begin
        mem_addr = cur_addr;
        state_nx = CHK;
      end
      CHK: begin
        if (mem_q == opp) begin
          n_nx = n_q + 3'd1;
          if (off_board) begin
            state_nx = NEXT_DIR;
          end else begin
            cur_r_nx    = next_r;
            cur_c_nx    = next_c;
            cur_addr_nx = next_addr;
            state_nx    = RD;
          end
        end else if (mem_q == own && n_q != 3'd0) begin
          state_nx = LOAD;
        end else begin
          state_nx = NEXT_DIR;
        end
      end
      LOAD: begin
        s_addr_out = s_addr_q;
        step_o     = cur_dir.step;
        ld_o       = 1'b1;
        tmo_nx     = '0;
        state_nx   = FLIP;
      end
      FLIP: begin
        mem_sel    = 1'b1;
        start_flip = 1'b1;
        if (s_done) begin
          flips_nx = flips_total + {2'b00, n_q};
          valid_nx = 1'b1;
          state_nx = NEXT_DIR;
        end else if (tmo_q == TW'(FLIP_TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          state_nx = NEXT_DIR;
        end else begin
          tmo_nx = tmo_q + TW'(1);
        end
      end
      NEXT_DIR: begin
        if (d_q == 3'd7) begin
          state_nx = PLACE;
        end else begin
          d_nx     = d_q + 3'd1;
          state_nx = DIR_SETUP;
        end
      end
      PLACE: begin
        if (move_valid) begin
          mem_addr = s_addr_q;
          mem_data = own;
          mem_wren = 1'b1;
        end
        state_nx = DONE;
      end
      DONE: begin
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a board-RAM model, a behavioural
// flipper behind the port mux, and bus-ownership monitors.
module tb_move_sequencer;
  import othello_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       player = 1'b0;
  logic [6:0] s_addr = '0;
  logic [1:0] mem_q;
  logic [6:0] mem_addr;
  logic       mem_wren;
  logic [1:0] mem_data;
  logic       mem_sel;
  logic [6:0] s_addr_out;
  logic [4:0] step_o;
  logic       ld_o;
  logic       start_flip;
  logic       s_done;
  logic       done_o;
  logic       move_valid;
  logic [4:0] flips_total;
  logic       err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  move_sequencer #(.FLIP_TIMEOUT(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .player      (player),
    .s_addr      (s_addr),
    .mem_q       (mem_q),
    .mem_addr    (mem_addr),
    .mem_wren    (mem_wren),
    .mem_data    (mem_data),
    .mem_sel     (mem_sel),
    .s_addr_out  (s_addr_out),
    .step_o      (step_o),
    .ld_o        (ld_o),
    .start_flip  (start_flip),
    .s_done      (s_done),
    .done_o      (done_o),
    .move_valid  (move_valid),
    .flips_total (flips_total),
    .err         (err)
  );

  // Board RAM with synchronous read and a whole-board preload path.
  logic [1:0] ram [64];
  logic [1:0] init_board [64];
  logic       load_board = 1'b0;
  logic [1:0] play_colour = BLACK;
  logic [1:0] opp_colour;
  logic       stuck = 1'b0;

  logic [6:0] f_pos;
  logic [6:0] f_step;
  logic       f_fin;
  logic       f_hit, f_wren;
  logic [6:0] port_addr;
  logic       port_wren;
  logic [1:0] port_data;

  assign opp_colour = play_colour ^ 2'b11;
  assign f_hit      = (ram[f_pos[5:0]] == opp_colour);
  assign f_wren     = start_flip && !stuck && !f_fin && f_hit;
  assign port_addr  = mem_sel ? f_pos : mem_addr;
  assign port_wren  = mem_sel ? f_wren : mem_wren;
  assign port_data  = mem_sel ? play_colour : mem_data;

  always @(posedge clock) begin
    if (load_board) begin
      ram <= init_board;
    end else begin
      mem_q <= ram[port_addr[5:0]];
      if (port_wren) ram[port_addr[5:0]] <= port_data;
    end
  end

  // Flipper: walks from s_addr+step overwriting opponent discs, then s_done.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_done <= 1'b0;
      f_fin  <= 1'b0;
      f_pos  <= '0;
      f_step <= '0;
    end else begin
      s_done <= 1'b0;
      if (ld_o) begin
        f_pos  <= s_addr_out + {{2{step_o[4]}}, step_o};
        f_step <= {{2{step_o[4]}}, step_o};
        f_fin  <= 1'b0;
      end else if (start_flip && !stuck && !f_fin) begin
        if (f_hit) begin
          f_pos <= f_pos + f_step;
        end else begin
          s_done <= 1'b1;
          f_fin  <= 1'b1;
        end
      end
    end
  end

  // Monitors sampled on the falling edge.
  int         conflicts = 0;
  int         dut_writes = 0;
  int         ld_count = 0;
  int         order_err = 0;
  int         run_len = 0;
  int         last_run = 0;
  logic [4:0] last_step = '0;
  logic [6:0] last_ld_addr = '0;
  logic       prev_ld = 1'b0;
  logic       prev_sf = 1'b0;

  always @(negedge clock) begin
    if ((mem_sel && mem_wren) || (start_flip != mem_sel)) conflicts <= conflicts + 1;
    if (mem_wren && !mem_sel) dut_writes <= dut_writes + 1;
    if (ld_o) begin
      ld_count     <= ld_count + 1;
      last_step    <= step_o;
      last_ld_addr <= s_addr_out;
    end
    if ((start_flip && !prev_sf && !prev_ld) || (prev_ld && !start_flip))
      order_err <= order_err + 1;
    prev_ld <= ld_o;
    prev_sf <= start_flip;
    if (start_flip) begin
      run_len <= run_len + 1;
    end else if (prev_sf) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) init_board[i] = EMPTY;
  endtask

  task automatic opening_board();
    clear_board();
    init_board[27] = WHITE;
    init_board[28] = BLACK;
    init_board[35] = BLACK;
    init_board[36] = WHITE;
  endtask

  task automatic load_ram();
    @(posedge clock); #1 load_board = 1'b1;
    @(posedge clock); #1 load_board = 1'b0;
  endtask

  // done_cycle counts cycles from the one carrying start (cycle 0); -1 on timeout.
  task automatic run_move(input logic pl, input logic [6:0] sq, input int budget,
                          output int done_cycle);
    play_colour = pl ? WHITE : BLACK;
    @(posedge clock); #1;
    start  = 1'b1;
    player = pl;
    s_addr = sq;
    done_cycle = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (done_o) begin
        done_cycle = k;
        break;
      end
      @(posedge clock); #1 start = 1'b0;
    end
    start = 1'b0;
  endtask

  int dc;
  int w0, l0;
  logic seen;

  initial begin
    opening_board();
    load_ram();
    @(negedge clock);
    check("rst_done",   32'(done_o), 0);
    check("rst_sel",    32'(mem_sel), 0);
    check("rst_flip",   32'(start_flip), 0);
    check("rst_err",    32'(err), 0);
    check("rst_valid",  32'(move_valid), 0);
    check("rst_flips",  32'(flips_total), 0);
    @(posedge clock); #1 reset = 1'b1;

    // Opening board, black at 19: only the south run encloses 27.
    w0 = dut_writes; l0 = ld_count;
    run_move(1'b0, 7'd19, 400, dc);
    check("t1_done_seen", 32'(dc >= 0), 1);
    check("t1_flips",     32'(flips_total), 1);
    check("t1_valid",     32'(move_valid), 1);
    check("t1_err",       32'(err), 0);
    check("t1_cell19",    32'(ram[19]), 32'(BLACK));
    check("t1_cell27",    32'(ram[27]), 32'(BLACK));
    check("t1_step",      32'(last_step), 32'(5'b01000));
    check("t1_ld_addr",   32'(last_ld_addr), 19);
    check("t1_ld_count",  32'(ld_count - l0), 1);
    check("t1_writes",    32'(dut_writes - w0), 1);

    // Occupied target 27: done in cycle 3, nothing written.
    w0 = dut_writes; l0 = ld_count;
    run_move(1'b0, 7'd27, 50, dc);
    check("t2_done_cycle", 32'(dc), 3);
    check("t2_valid",      32'(move_valid), 0);
    check("t2_flips",      32'(flips_total), 0);
    check("t2_writes",     32'(dut_writes - w0), 0);
    check("t2_ld_count",   32'(ld_count - l0), 0);

    // Black at 7: east edge must not wrap into row 1 (8=W, 9=B would enclose).
    clear_board();
    init_board[6] = WHITE;
    init_board[8] = WHITE;
    init_board[9] = BLACK;
    load_ram();
    w0 = dut_writes; l0 = ld_count;
    run_move(1'b0, 7'd7, 400, dc);
    check("t3_done_seen", 32'(dc >= 0), 1);
    check("t3_valid",     32'(move_valid), 0);
    check("t3_flips",     32'(flips_total), 0);
    check("t3_ld_count",  32'(ld_count - l0), 0);
    check("t3_writes",    32'(dut_writes - w0), 0);
    check("t3_cell8",     32'(ram[8]), 32'(WHITE));
    check("t3_cell7",     32'(ram[7]), 32'(EMPTY));

    // White at 0 with B at 1..6, W at 7: six flips eastward.
    clear_board();
    for (int i = 1; i <= 6; i++) init_board[i] = BLACK;
    init_board[7] = WHITE;
    load_ram();
    run_move(1'b1, 7'd0, 400, dc);
    check("t4_done_seen", 32'(dc >= 0), 1);
    check("t4_flips",     32'(flips_total), 6);
    check("t4_valid",     32'(move_valid), 1);
    check("t4_step",      32'(last_step), 32'(5'b00001));
    check("t4_ld_addr",   32'(last_ld_addr), 0);
    for (int i = 0; i <= 7; i++) check($sformatf("t4_cell%0d", i), 32'(ram[i]), 32'(WHITE));

    // Flipper never answers: 64 FLIP cycles, err set, move still completes.
    opening_board();
    load_ram();
    stuck = 1'b1;
    w0 = dut_writes;
    run_move(1'b0, 7'd19, 1000, dc);
    check("t5_done_seen", 32'(dc >= 0), 1);
    check("t5_err",       32'(err), 1);
    check("t5_flip_run",  32'(last_run), 64);
    check("t5_valid",     32'(move_valid), 0);
    check("t5_flips",     32'(flips_total), 0);
    check("t5_writes",    32'(dut_writes - w0), 0);
    check("t5_cell19",    32'(ram[19]), 32'(EMPTY));
    check("t5_cell27",    32'(ram[27]), 32'(WHITE));

    // Reset in the middle of FLIP.
    play_colour = BLACK;
    @(posedge clock); #1;
    start = 1'b1; player = 1'b0; s_addr = 7'd19;
    @(posedge clock); #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (start_flip) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_flip_reached", 32'(seen), 1);
    reset = 1'b0;
    #1;
    check("t6_sel",   32'(mem_sel), 0);
    check("t6_flip",  32'(start_flip), 0);
    check("t6_err",   32'(err), 0);
    check("t6_ld",    32'(ld_o), 0);
    check("t6_wren",  32'(mem_wren), 0);
    check("t6_addr",  32'(mem_addr), 0);
    check("t6_done",  32'(done_o), 0);
    check("t6_valid", 32'(move_valid), 0);
    check("t6_flips", 32'(flips_total), 0);
    @(posedge clock); #1 reset = 1'b1;
    stuck = 1'b0;
    opening_board();
    load_ram();
    run_move(1'b0, 7'd19, 400, dc);
    check("t6_rerun_done",  32'(dc >= 0), 1);
    check("t6_rerun_flips", 32'(flips_total), 1);
    check("t6_rerun_valid", 32'(move_valid), 1);
    check("t6_rerun_err",   32'(err), 0);
    check("t6_rerun_cell",  32'(ram[27]), 32'(BLACK));

    @(negedge clock);
    check("bus_conflicts", 32'(conflicts), 0);
    check("ld_flip_order", 32'(order_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
